// File: rtl/ecap5_dproc_pkg.sv
// Shared types and constants for the decode/execute pipeline stage.
package ecap5_dproc_pkg;

  localparam int unsigned PERF_CNT_WIDTH = 32;

  // Stage occupancy, encoded as {skid_valid, main_valid}.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } occ_state_e;

endpackage

// File: rtl/pipe_stage_sat_counter.sv
// Enable-driven saturating up-counter; sticks at all-ones.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: increment when enabled unless already saturated.
  always_comb begin
    count_d = count_q;
    if (en_i && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipe_stage.sv
// Decode->execute stage register: valid/ready handshake with a two-slot
// (main + skid) buffer so input_ready_o comes straight from state flops.
// Hazard stall presents a bubble downstream; hazard discard flushes the stage.
// Optional performance counters enabled by defining PIPE_STAGE_PERF_EN.
module pipe_stage
  import ecap5_dproc_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      input_valid_i,
  output logic                      input_ready_o,
  input  logic [DATA_WIDTH-1:0]     input_data_i,
  output logic                      output_valid_o,
  input  logic                      output_ready_i,
  output logic [DATA_WIDTH-1:0]     output_data_o,
  input  logic                      stall_request_i,
  input  logic                      discard_request_i,
  output logic [PERF_CNT_WIDTH-1:0] stall_cycles_o,
  output logic [PERF_CNT_WIDTH-1:0] discard_count_o
);

  occ_state_e            state_q;
  occ_state_e            state_d;
  logic [DATA_WIDTH-1:0] main_q;
  logic [DATA_WIDTH-1:0] main_d;
  logic [DATA_WIDTH-1:0] skid_q;
  logic [DATA_WIDTH-1:0] skid_d;
  logic                  main_valid;
  logic                  skid_valid;
  logic                  in_xfer;
  logic                  out_xfer;

  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);

  // Ready depends only on the registered occupancy.
  assign input_ready_o  = !skid_valid;
  assign in_xfer        = input_valid_i && input_ready_o && !discard_request_i;
  assign output_valid_o = main_valid && !stall_request_i && !discard_request_i;
  assign output_data_o  = main_q;
  assign out_xfer       = output_valid_o && output_ready_i;

  // Next occupancy and data; main always holds the older payload.
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (discard_request_i) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_xfer) begin
            state_d = ONE;
            main_d  = input_data_i;
          end
        end
        ONE: begin
          if (out_xfer && in_xfer) begin
            main_d = input_data_i;
          end else if (out_xfer) begin
            state_d = EMPTY;
          end else if (in_xfer) begin
            state_d = FULL;
            skid_d  = input_data_i;
          end
        end
        FULL: begin
          if (out_xfer) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: begin
          state_d = EMPTY;
        end
      endcase
    end
  end

  // State and payload registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic stall_cnt_en;
  logic discard_cnt_en;

  assign stall_cnt_en   = stall_request_i && main_valid && !discard_request_i;
  assign discard_cnt_en = discard_request_i && (main_valid || input_valid_i);

  sat_counter #(
    .WIDTH (PERF_CNT_WIDTH)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (stall_cnt_en),
    .count_o (stall_cycles_o)
  );

  sat_counter #(
    .WIDTH (PERF_CNT_WIDTH)
  ) u_discard_cnt (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .en_i    (discard_cnt_en),
    .count_o (discard_count_o)
  );
`else
  assign stall_cycles_o  = '0;
  assign discard_count_o = '0;
`endif

endmodule
